// File: rtl/collision_avoid_drive.sv
// Obstacle-avoidance motor controller: confirms repeated crash hits, then runs a timed
// brake / reverse / turn / resume sequence with dead-time-protected PWM on both motors.
module collision_avoid_drive #(
    parameter int PWM_PERIOD = 10000,
    parameter int DUTY_W     = 14,
    parameter int HIT_COUNT  = 3,
    parameter int WINDOW_CYC = 5_000_000,
    parameter int DEAD_CYC   = 1000,
    parameter int BRAKE_CYC  = 10_000_000,
    parameter int REV_CYC    = 50_000_000,
    parameter int TURN_CYC   = 30_000_000,
    parameter int REV_DUTY   = 6000,
    parameter int TURN_DUTY  = 5000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              crash_in,
    input  logic [DUTY_W-1:0] cmd_duty,
    output logic              pwm_l,
    output logic              pwm_r,
    output logic              dir_l,
    output logic              dir_r,
    output logic              obstacle,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FWD   = 3'd1,
        S_BRAKE = 3'd2,
        S_REV   = 3'd3,
        S_TURN  = 3'd4
    } state_t;

    localparam int TMR_MAX = (BRAKE_CYC > REV_CYC) ?
                             ((BRAKE_CYC > TURN_CYC) ? BRAKE_CYC : TURN_CYC) :
                             ((REV_CYC > TURN_CYC) ? REV_CYC : TURN_CYC);
    localparam int TMR_W  = $clog2(TMR_MAX + 1);
    localparam int WIN_W  = $clog2(WINDOW_CYC + 1);
    localparam int HIT_W  = $clog2(HIT_COUNT + 1);
    localparam int DEAD_W = $clog2(DEAD_CYC + 1);

    localparam logic [TMR_W-1:0]  BRAKE_LAST  = TMR_W'(BRAKE_CYC - 1);
    localparam logic [TMR_W-1:0]  REV_LAST    = TMR_W'(REV_CYC - 1);
    localparam logic [TMR_W-1:0]  TURN_LAST   = TMR_W'(TURN_CYC - 1);
    localparam logic [TMR_W-1:0]  TMR_TOP     = {TMR_W{1'b1}};
    localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(WINDOW_CYC);
    localparam logic [HIT_W-1:0]  HIT_MAX     = HIT_W'(HIT_COUNT);
    localparam logic [DEAD_W-1:0] DEAD_LAST   = DEAD_W'(DEAD_CYC - 1);
    localparam logic [DUTY_W-1:0] PERIOD_V    = DUTY_W'(PWM_PERIOD);
    localparam logic [DUTY_W-1:0] CNT_LAST    = DUTY_W'(PWM_PERIOD - 1);
    localparam logic [DUTY_W-1:0] REV_DUTY_V  = DUTY_W'(REV_DUTY);
    localparam logic [DUTY_W-1:0] TURN_DUTY_V = DUTY_W'(TURN_DUTY);

    state_t            state_q, state_d;
    logic              crash_q, crash_prev_q, edge_q;
    logic [HIT_W-1:0]  hits_q, hits_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DEAD_W-1:0] dead_q, dead_d;
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic [DUTY_W-1:0] duty_s, duty_clamp_s;
    logic              state_chg_s;
    logic              pwm_q, pwm_d;
    logic              dir_l_q, dir_l_d, dir_r_q, dir_r_d;
    logic              obstacle_q, obstacle_d;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; enable low overrides every other condition
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_FWD;
                S_FWD:   state_d = (hits_q == HIT_MAX)     ? S_BRAKE : S_FWD;
                S_BRAKE: state_d = (timer_q == BRAKE_LAST) ? S_REV   : S_BRAKE;
                S_REV:   state_d = (timer_q == REV_LAST)   ? S_TURN  : S_REV;
                S_TURN:  state_d = (timer_q == TURN_LAST)  ? S_FWD   : S_TURN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM output decode, taken from the next state so directions move on the transition clock
    always_comb begin
        duty_s  = '0;
        dir_l_d = dir_l_q;
        dir_r_d = dir_r_q;
        case (state_d)
            S_FWD: begin
                duty_s  = cmd_duty;
                dir_l_d = 1'b1;
                dir_r_d = 1'b1;
            end
            S_REV: begin
                duty_s  = REV_DUTY_V;
                dir_l_d = 1'b0;
                dir_r_d = 1'b0;
            end
            S_TURN: begin
                duty_s  = TURN_DUTY_V;
                dir_l_d = 1'b1;
                dir_r_d = 1'b0;
            end
            S_IDLE, S_BRAKE: begin
                duty_s = '0;
            end
            default: begin
                duty_s  = '0;
                dir_l_d = 1'b1;
                dir_r_d = 1'b1;
            end
        endcase
        if (state_d == S_BRAKE && state_q != S_BRAKE) begin
            obstacle_d = 1'b1;
        end else if (state_d == S_IDLE) begin
            obstacle_d = 1'b0;
        end else if (state_q == S_TURN && state_d != S_TURN) begin
            obstacle_d = 1'b0;
        end else begin
            obstacle_d = obstacle_q;
        end
    end

    // Hit window, state timer, dead time and PWM next-state logic
    always_comb begin
        state_chg_s = (state_d != state_q);

        if (edge_q) begin
            win_d = '0;
        end else if (win_q != WIN_LAST) begin
            win_d = win_q + 1'b1;
        end else begin
            win_d = win_q;
        end

        if (state_q != S_FWD) begin
            hits_d = '0;
        end else if (edge_q) begin
            hits_d = (hits_q != HIT_MAX) ? hits_q + 1'b1 : hits_q;
        end else if (win_q == WIN_LAST) begin
            hits_d = '0;
        end else begin
            hits_d = hits_q;
        end

        if (state_chg_s) begin
            timer_d = '0;
        end else if (timer_q != TMR_TOP) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end

        // The transition clock itself is the first of the DEAD_CYC low clocks
        if (state_chg_s) begin
            dead_d = DEAD_LAST;
        end else if (dead_q != '0) begin
            dead_d = dead_q - 1'b1;
        end else begin
            dead_d = dead_q;
        end

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        duty_clamp_s = (duty_s > PERIOD_V) ? PERIOD_V : duty_s;
        pwm_d        = !state_chg_s && (dead_q == '0) && (cnt_q < duty_clamp_s);
    end

    // Datapath registers: crash edge pipeline, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            crash_q      <= 1'b0;
            crash_prev_q <= 1'b0;
            edge_q       <= 1'b0;
            hits_q       <= '0;
            win_q        <= '0;
            timer_q      <= '0;
            dead_q       <= '0;
            cnt_q        <= '0;
            pwm_q        <= 1'b0;
            dir_l_q      <= 1'b1;
            dir_r_q      <= 1'b1;
            obstacle_q   <= 1'b0;
        end else begin
            crash_q      <= crash_in;
            crash_prev_q <= crash_q;
            edge_q       <= crash_q & ~crash_prev_q;
            hits_q       <= hits_d;
            win_q        <= win_d;
            timer_q      <= timer_d;
            dead_q       <= dead_d;
            cnt_q        <= cnt_d;
            pwm_q        <= pwm_d;
            dir_l_q      <= dir_l_d;
            dir_r_q      <= dir_r_d;
            obstacle_q   <= obstacle_d;
        end
    end

    assign pwm_l    = pwm_q;
    assign pwm_r    = pwm_q;
    assign dir_l    = dir_l_q;
    assign dir_r    = dir_r_q;
    assign obstacle = obstacle_q;
    assign state    = state_q;

endmodule
